food_map_arbiter: RTL and testbench
===================================

FOOD_MAP_ARBITER -- requirements
Module: food_map_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports "clk" and "rst".
REQ-002 The module SHALL have parameter ROWS, default 50, giving the number of food-map rows.
REQ-003 The module SHALL have parameter COLS, default 80, giving the number of bits per row.
REQ-004 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- render_y  in  6  row wanted by the renderer.
- render_row  out  80  registered food row for render_y.
- eat_valid  in  1  game-logic eat request.
- eat_x  in  7  column to clear.
- eat_y  in  6  row to clear.
- eat_ready  out  1  eat request accepted this cycle when high with eat_valid.
- eat_done  out  1  one-cycle pulse: eat operation finished.
- eat_hit  out  1  valid with eat_done: the bit was 1 and is now cleared.
- fill_req  in  1  one-cycle pulse: refill the whole map.
- fill_busy  out  1  refill in progress.
- food_count  out  12  number of food bits currently set.
- level_clear  out  1  one-cycle pulse when food_count goes from 1 to 0.
- mem_addr  out  6  external single-port RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  80  RAM write data.
- mem_rdata  in  80  RAM read data, valid 1 cycle after mem_addr is presented with mem_we=0.

Function
REQ-005 The module SHALL share the single-port food RAM between renderer reads, eat read-modify-writes and refill writes, using FSM states IDLE, R_WAIT, E_WAIT, E_WRITE and FILL.
REQ-006 The module SHALL keep a cached row index and a stale flag; a render refresh is pending when the stale flag is set or render_y differs from the cached row index.
REQ-007 Arbitration in IDLE SHALL use fixed priority: pending render refresh, then fill, then eat.
REQ-008 The module SHALL assert eat_ready combinationally only when all of the following hold: state is IDLE, no render refresh is pending, and no fill is latched.
REQ-009 When a render refresh is issued, the module SHALL drive mem_addr=render_y with mem_we=0, latch render_y, and go to R_WAIT; R_WAIT SHALL load render_row from mem_rdata, update the cached row index, clear the stale flag, and return to IDLE.
REQ-010 If render_y >= ROWS, the module SHALL load render_row with 0 without accessing the RAM, update the cached row index, and take one cycle in IDLE.
REQ-011 When eat_valid and eat_ready are both high, the module SHALL latch eat_x and eat_y, read row eat_y, and go to E_WAIT.
REQ-012 In E_WAIT, if bit eat_x of mem_rdata is 0, the module SHALL pulse eat_done with eat_hit=0 and return to IDLE with no write.
REQ-013 In E_WAIT, if bit eat_x is 1, the module SHALL go to E_WRITE and write the row with only bit eat_x cleared.
REQ-014 In E_WRITE, the module SHALL pulse eat_done with eat_hit=1 and decrement food_count by 1, saturating at 0.
REQ-015 If the eaten row equals the cached row index and the stale flag is clear, the module SHALL update render_row in E_WRITE with the same bit cleared (coherency), with no re-read.
REQ-016 If eat_x >= COLS or eat_y >= ROWS, the module SHALL pulse eat_done with eat_hit=0 on the cycle after acceptance and SHALL NOT access the RAM.
REQ-017 fill_req SHALL be latched in any state and serviced from IDLE.
REQ-018 FILL SHALL write all-ones to rows 0..ROWS-1, one row per cycle, with fill_busy high throughout.
REQ-019 On completing FILL, the module SHALL set food_count to ROWS*COLS (4000), set the stale flag, and return to IDLE.
REQ-020 A fill_req arriving during FILL SHALL be ignored.
REQ-021 Render refreshes SHALL wait until FILL completes.
REQ-022 The module SHALL pulse level_clear in the same cycle food_count changes from 1 to 0, and SHALL NOT pulse it when food_count is loaded or reset.
REQ-023 Latency: render_row SHALL reflect a new render_y within 3 cycles of the change when the FSM is idle, and within 6 cycles when an eat operation is in flight; FILL time is excluded from both bounds.
REQ-024 An eat operation, from acceptance to eat_done, SHALL take 2 cycles on a miss and 3 cycles on a hit.

Reset
REQ-025 When rst is high at a clock edge, the module SHALL set: state IDLE, render_row=0, stale flag=1, cached row index=0, eat_done=0, eat_hit=0, fill_busy=0, latched fill cleared, food_count=0, level_clear=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-026 A reset during FILL or E_WRITE SHALL abort the operation immediately; RAM contents are then undefined, and the next fill_req SHALL restore a full map.

Verification
REQ-027 Bench: reset, then fill_req -> fill_busy high for 50 cycles, 50 writes to addresses 0..49 of all-ones, food_count=4000, render_row=all-ones for render_y=0.
REQ-028 Bench: after fill, eat (x=5, y=3) -> eat_hit=1, RAM row 3 = all-ones with bit 5 clear, food_count=3999; repeating the same eat -> eat_hit=0, count unchanged.
REQ-029 Bench: render_y=3 cached, eat (x=79, y=3) -> render_row bit 79 clears in E_WRITE with no extra RAM read.
REQ-030 Bench: eat_valid held while render_y changes every cycle -> eat_ready stays low until render_y is stable, then the eat completes; render_row is always correct.
REQ-031 Bench: eat (x=80, y=10) and eat (x=0, y=50) -> each gives eat_done with eat_hit=0 and no mem_we.
REQ-032 Bench: force food_count=1 via 3999 eats, eat the last bit -> level_clear pulses once and food_count=0; rst asserted mid-FILL -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/food_map_arbiter.sv
// food_map_arbiter
//   Shares one single-port food RAM (one ROWS x COLS bitmap) between three
//   clients: the renderer (reads one row, cached in render_row), the game
//   logic (eat = read-modify-write clearing one bit) and the refill engine
//   (writes all-ones to every row).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   render_y         row the renderer wants; render_row is the registered copy
//   eat_valid/ready  eat handshake carrying eat_x / eat_y
//   eat_done/hit     one-cycle completion pulse, hit = bit was set and cleared
//   fill_req         one-cycle pulse requesting a full refill; fill_busy while running
//   food_count       number of set food bits; level_clear pulses on 1 -> 0
//   mem_*            external RAM port, read data returns one cycle after address
module food_map_arbiter #(
    parameter int ROWS = 50,
    parameter int COLS = 80
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      render_y,
    output logic [COLS-1:0] render_row,
    input  logic            eat_valid,
    input  logic [6:0]      eat_x,
    input  logic [5:0]      eat_y,
    output logic            eat_ready,
    output logic            eat_done,
    output logic            eat_hit,
    input  logic            fill_req,
    output logic            fill_busy,
    output logic [11:0]     food_count,
    output logic            level_clear,
    output logic [5:0]      mem_addr,
    output logic            mem_we,
    output logic [COLS-1:0] mem_wdata,
    input  logic [COLS-1:0] mem_rdata
);

    localparam logic [5:0] ROWS_L = 6'(ROWS);
    localparam logic [6:0] COLS_L = 7'(COLS);

    typedef enum logic [2:0] {IDLE, R_WAIT, E_WAIT, E_WRITE, FILL} state_t;

    state_t          state_q, state_d;
    logic [COLS-1:0] render_row_q, render_row_d;
    logic [5:0]      cached_q, cached_d;
    logic            stale_q, stale_d;
    logic [5:0]      ry_q, ry_d;
    logic [6:0]      ex_q, ex_d;
    logic [5:0]      ey_q, ey_d;
    logic [COLS-1:0] row_q, row_d;
    logic            fill_q, fill_d;
    logic [5:0]      fcnt_q, fcnt_d;
    logic [11:0]     count_q, count_d;
    logic            done_q, done_d;
    logic            hit_q, hit_d;
    logic            lc_q, lc_d;

    logic            pending;
    logic [COLS-1:0] clr_mask;

    assign pending     = stale_q || (render_y != cached_q);
    assign eat_ready   = (state_q == IDLE) && !pending && !fill_q;
    assign render_row  = render_row_q;
    assign eat_done    = done_q;
    assign eat_hit     = hit_q;
    assign fill_busy   = (state_q == FILL);
    assign food_count  = count_q;
    assign level_clear = lc_q;

    // Mask with only the latched eat column cleared.
    always_comb begin
        clr_mask       = '1;
        clr_mask[ex_q] = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        render_row_d = render_row_q;
        cached_d     = cached_q;
        stale_d      = stale_q;
        ry_d         = ry_q;
        ex_d         = ex_q;
        ey_d         = ey_q;
        row_d        = row_q;
        fill_d       = fill_q;
        fcnt_d       = fcnt_q;
        count_d      = count_q;
        done_d       = 1'b0;
        hit_d        = 1'b0;
        lc_d         = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        // A refill request is remembered until IDLE can start it; while a
        // refill is already running a new request has nothing to add.
        if (fill_req && state_q != FILL) fill_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pending) begin
                    if (render_y >= ROWS_L) begin
                        // Off-map rows render as empty without touching the RAM.
                        render_row_d = '0;
                        cached_d     = render_y;
                        stale_d      = 1'b0;
                    end else begin
                        mem_addr = render_y;
                        ry_d     = render_y;
                        state_d  = R_WAIT;
                    end
                end else if (fill_q) begin
                    fill_d  = 1'b0;
                    fcnt_d  = '0;
                    state_d = FILL;
                end else if (eat_valid) begin
                    ex_d = eat_x;
                    ey_d = eat_y;
                    if (eat_x >= COLS_L || eat_y >= ROWS_L) begin
                        done_d = 1'b1;
                    end else begin
                        mem_addr = eat_y;
                        state_d  = E_WAIT;
                    end
                end
            end
            R_WAIT: begin
                render_row_d = mem_rdata;
                cached_d     = ry_q;
                stale_d      = 1'b0;
                state_d      = IDLE;
            end
            E_WAIT: begin
                if (mem_rdata[ex_q]) begin
                    row_d   = mem_rdata & clr_mask;
                    state_d = E_WRITE;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            E_WRITE: begin
                mem_addr  = ey_q;
                mem_we    = 1'b1;
                mem_wdata = row_q;
                done_d    = 1'b1;
                hit_d     = 1'b1;
                count_d   = (count_q == 12'd0) ? 12'd0 : count_q - 12'd1;
                lc_d      = (count_q == 12'd1);
                // Keep the cached render row coherent instead of re-reading it.
                if (ey_q == cached_q && !stale_q) render_row_d = render_row_q & clr_mask;
                state_d   = IDLE;
            end
            FILL: begin
                mem_addr  = fcnt_q;
                mem_we    = 1'b1;
                mem_wdata = '1;
                fcnt_d    = fcnt_q + 6'd1;
                if (fcnt_q == ROWS_L - 6'd1) begin
                    count_d = 12'(ROWS * COLS);
                    stale_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            render_row_q <= '0;
            cached_q     <= '0;
            stale_q      <= 1'b1;
            ry_q         <= '0;
            ex_q         <= '0;
            ey_q         <= '0;
            row_q        <= '0;
            fill_q       <= 1'b0;
            fcnt_q       <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            lc_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            render_row_q <= render_row_d;
            cached_q     <= cached_d;
            stale_q      <= stale_d;
            ry_q         <= ry_d;
            ex_q         <= ex_d;
            ey_q         <= ey_d;
            row_q        <= row_d;
            fill_q       <= fill_d;
            fcnt_q       <= fcnt_d;
            count_q      <= count_d;
            done_q       <= done_d;
            hit_q        <= hit_d;
            lc_q         <= lc_d;
        end
    end

endmodule

// File: tb/tb_food_map_arbiter.sv
module tb_food_map_arbiter;

    localparam logic [79:0] ONES = '1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  render_y = '0;
    logic [79:0] render_row;
    logic        eat_valid = 1'b0;
    logic [6:0]  eat_x = '0;
    logic [5:0]  eat_y = '0;
    logic        eat_ready, eat_done, eat_hit;
    logic        fill_req = 1'b0;
    logic        fill_busy;
    logic [11:0] food_count;
    logic        level_clear;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [79:0] mem_wdata;
    logic [79:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int lc_cnt = 0;

    logic [79:0] ram   [0:63];
    logic [79:0] model [0:49];

    food_map_arbiter dut (
        .clk(clk), .rst(rst), .render_y(render_y), .render_row(render_row),
        .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y), .eat_ready(eat_ready),
        .eat_done(eat_done), .eat_hit(eat_hit), .fill_req(fill_req), .fill_busy(fill_busy),
        .food_count(food_count), .level_clear(level_clear), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: synchronous write, one-cycle registered read.
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) if (level_clear === 1'b1) lc_cnt <= lc_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where eat_done is seen.
    // lat = cycles from the acceptance cycle to the eat_done cycle.
    task automatic do_eat(input logic [6:0] x, input logic [5:0] y,
                          output logic hit, output int lat, output logic we_seen, output logic ok);
        int n;
        ok = 1'b0; hit = 1'b0; lat = 0; we_seen = 1'b0;
        eat_x = x; eat_y = y; eat_valid = 1'b1;
        #1;
        n = 0;
        while (!eat_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!eat_ready) begin
            eat_valid = 1'b0;
            return;
        end
        @(negedge clk);
        eat_valid = 1'b0;
        lat = 1;
        while (!eat_done && lat < 10) begin
            if (mem_we) we_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (eat_done) begin
            ok  = 1'b1;
            hit = eat_hit;
        end
        if (x < 80 && y < 50) model[y][x] = 1'b0;
    endtask

    task automatic do_fill(input logic poke, output int busy, output int bad);
        int n;
        busy = 0; bad = 0;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        n = 0;
        while (!fill_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (fill_busy && busy < 100) begin
            if (!mem_we || mem_addr != 6'(busy) || mem_wdata != ONES) bad++;
            if (poke) fill_req = (busy == 10);
            @(negedge clk);
            busy++;
        end
        fill_req = 1'b0;
        for (int r = 0; r < 50; r++) model[r] = ONES;
    endtask

    typedef struct {
        logic [6:0]  x;
        logic [5:0]  y;
        logic        hit;
        int          lat;
        logic [11:0] cnt;
    } eat_vec_t;

    eat_vec_t ev [5];

    initial begin
        logic        hit, we_seen, ok;
        int          lat, busy, bad, bulk_bad, rdy_bad;
        logic [79:0] exp_row;
        logic [5:0]  ys [6];

        ev[0] = '{x: 7'd5,  y: 6'd3,  hit: 1'b1, lat: 3, cnt: 12'd3999};
        ev[1] = '{x: 7'd5,  y: 6'd3,  hit: 1'b0, lat: 2, cnt: 12'd3999};
        ev[2] = '{x: 7'd80, y: 6'd10, hit: 1'b0, lat: 1, cnt: 12'd3999};
        ev[3] = '{x: 7'd0,  y: 6'd50, hit: 1'b0, lat: 1, cnt: 12'd3999};
        ev[4] = '{x: 7'd0,  y: 6'd0,  hit: 1'b1, lat: 3, cnt: 12'd3998};
        ys = '{6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7};
        for (int r = 0; r < 50; r++) model[r] = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_render_row", render_row, '0);
        chk("rst_eat_done",   eat_done, 1'b0);
        chk("rst_eat_hit",    eat_hit, 1'b0);
        chk("rst_fill_busy",  fill_busy, 1'b0);
        chk("rst_food_count", food_count, 12'd0);
        chk("rst_level_clr",  level_clear, 1'b0);
        chk("rst_mem_we",     mem_we, 1'b0);
        chk("rst_mem_addr",   mem_addr, 6'd0);
        chk("rst_mem_wdata",  mem_wdata, '0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Refill, with a fill_req poked mid-fill that must be ignored
        do_fill(1'b1, busy, bad);
        chk("fill_busy_cycles", busy, 50);
        chk("fill_bad_writes",  bad, 0);
        chk("fill_count",       food_count, 12'd4000);
        repeat (5) @(negedge clk);
        chk("fill_req_ignored", fill_busy, 1'b0);
        chk("fill_render_row0", render_row, ONES);

        // Table of eats
        for (int i = 0; i < 5; i++) begin
            do_eat(ev[i].x, ev[i].y, hit, lat, we_seen, ok);
            chk($sformatf("eat%0d_done", i),  ok, 1'b1);
            chk($sformatf("eat%0d_hit", i),   hit, ev[i].hit);
            chk($sformatf("eat%0d_lat", i),   lat, ev[i].lat);
            chk($sformatf("eat%0d_we", i),    we_seen, ev[i].hit);
            chk($sformatf("eat%0d_count", i), food_count, ev[i].cnt);
            @(negedge clk);
        end
        exp_row = ONES; exp_row[5] = 1'b0;
        chk("ram_row3", ram[3], exp_row);
        exp_row = ONES; exp_row[0] = 1'b0;
        chk("coherent_row0", render_row, exp_row);

        // Render latency: off-map row in one cycle, idle refresh within 3
        render_y = 6'd55;
        @(negedge clk);
        chk("render_offmap", render_row, '0);
        render_y = 6'd3;
        repeat (3) @(negedge clk);
        exp_row = ONES; exp_row[5] = 1'b0;
        chk("render_row3", render_row, exp_row);

        // Coherent update of the cached row on the eat_done cycle itself
        do_eat(7'd79, 6'd3, hit, lat, we_seen, ok);
        chk("coh_hit", hit, 1'b1);
        exp_row[79] = 1'b0;
        chk("coh_render_row", render_row, exp_row);
        chk("coh_ram_row3", ram[3], exp_row);
        @(negedge clk);

        // Eat held while the renderer keeps moving
        rdy_bad = 0;
        for (int i = 0; i < 6; i++) begin
            render_y = ys[i]; eat_valid = 1'b1; eat_x = 7'd10; eat_y = 6'd20;
            #1;
            if (eat_ready) rdy_bad++;
            @(negedge clk);
        end
        chk("ready_low_moving", rdy_bad, 0);
        do_eat(7'd10, 6'd20, hit, lat, we_seen, ok);
        chk("moving_eat_hit", hit, 1'b1);
        chk("moving_render7", render_row, ONES);
        chk("moving_count", food_count, 12'd3996);
        @(negedge clk);

        // Eat everything except the last bit
        bulk_bad = 0;
        for (int y = 0; y < 50; y++)
            for (int x = 0; x < 80; x++)
                if (model[y][x] && !(y == 49 && x == 79)) begin
                    do_eat(7'(x), 6'(y), hit, lat, we_seen, ok);
                    if (!ok || !hit) bulk_bad++;
                end
        @(negedge clk);
        chk("bulk_hits", bulk_bad, 0);
        chk("bulk_count", food_count, 12'd1);
        chk("bulk_no_clear", lc_cnt, 0);
        do_eat(7'd79, 6'd49, hit, lat, we_seen, ok);
        chk("last_hit", hit, 1'b1);
        chk("last_count", food_count, 12'd0);
        chk("last_level_clear", level_clear, 1'b1);
        @(negedge clk);
        chk("level_clear_pulse", level_clear, 1'b0);
        do_eat(7'd79, 6'd49, hit, lat, we_seen, ok);
        chk("empty_miss", hit, 1'b0);
        chk("empty_count", food_count, 12'd0);
        @(negedge clk);

        // Reset during FILL
        render_y = 6'd0;
        repeat (4) @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("midfill_busy", fill_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_fill_busy",  fill_busy, 1'b0);
        chk("midrst_render_row", render_row, '0);
        chk("midrst_count",      food_count, 12'd0);
        chk("midrst_done",       eat_done, 1'b0);
        chk("midrst_hit",        eat_hit, 1'b0);
        chk("midrst_lc",         level_clear, 1'b0);
        chk("midrst_mem_we",     mem_we, 1'b0);
        chk("midrst_mem_addr",   mem_addr, 6'd0);
        chk("midrst_mem_wdata",  mem_wdata, '0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_resume", fill_busy, 1'b0);

        // Next refill restores a full map
        do_fill(1'b0, busy, bad);
        chk("refill_busy", busy, 50);
        chk("refill_count", food_count, 12'd4000);
        bad = 0;
        for (int r = 0; r < 50; r++) if (ram[r] !== ONES) bad++;
        chk("refill_ram_full", bad, 0);
        chk("level_clear_total", lc_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
